// File: rtl/alu_defs.sv
// Shared definitions for the execute-stage arithmetic units.
// Provides the operand width, the divide operation codes (funct3[1:0]),
// the divider state encoding and small op-decode helpers.
package alu_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic is_signed_op(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic is_rem_op(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider (combinational).
// Ports:
//   rem_in   - current partial remainder (XLEN+1 bits)
//   dvd_msb  - dividend bit shifted into the remainder this step
//   divisor  - divisor magnitude
//   rem_out  - partial remainder after the step
//   q_bit    - quotient bit produced by the step
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;

  // One guard bit above the remainder so the borrow lands in the MSB.
  assign shifted = {rem_in, dvd_msb};
  assign trial   = shifted - {2'b00, divisor};
  assign q_bit   = ~trial[XLEN+1];
  assign rem_out = q_bit ? trial[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/divider.sv
// Iterative RV32M divide unit (div, divu, rem, remu), one quotient bit per
// clock using a restoring datapath. Operations are issued over an
// in_valid/in_ready handshake and retired over out_valid/out_ready.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid, in_ready   - issue handshake
//   operand_a, operand_b - dividend, divisor
//   div_op               - funct3[1:0]: 00 div, 01 divu, 10 rem, 11 remu
//   out_valid, out_ready - result handshake
//   h                    - quotient or remainder
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// CALC  | shifting out one quotient bit per cycle
// DONE  | result held on h, out_valid high
module divider #(
  parameter int XLEN = alu_defs::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [1:0]      div_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] h
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_defs::div_state_e state;
  alu_defs::div_op_e    op_q;
  alu_defs::div_op_e    op_in;

  logic [XLEN-1:0]  dvd;
  logic [XLEN-1:0]  dvs;
  logic [XLEN:0]    rem;
  logic [CNT_W-1:0] count;
  logic             neg_q;
  logic             neg_r;

  logic            sgn_in;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            overflow;

  logic [XLEN:0]   rem_nxt;
  logic            q_bit;
  logic [XLEN-1:0] q_raw;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign op_in    = alu_defs::div_op_e'(div_op);
  assign sgn_in   = alu_defs::is_signed_op(op_in);
  assign abs_a    = (sgn_in && operand_a[XLEN-1]) ? -operand_a : operand_a;
  assign abs_b    = (sgn_in && operand_b[XLEN-1]) ? -operand_b : operand_b;
  assign div_zero = (operand_b == '0);
  assign overflow = sgn_in && (operand_a == MIN_NEG) && (operand_b == '1);

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem),
    .dvd_msb (dvd[XLEN-1]),
    .divisor (dvs),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // The dividend register doubles as the quotient shift register.
  assign q_raw = {dvd[XLEN-2:0], q_bit};
  assign q_fix = (alu_defs::is_signed_op(op_q) && neg_q) ? -q_raw : q_raw;
  assign r_fix = (alu_defs::is_signed_op(op_q) && neg_r) ? -rem_nxt[XLEN-1:0]
                                                         : rem_nxt[XLEN-1:0];

  assign in_ready  = (state == alu_defs::IDLE);
  assign out_valid = (state == alu_defs::DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= alu_defs::IDLE;
      op_q  <= alu_defs::DIV;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      count <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      h     <= '0;
    end else begin
      case (state)
        alu_defs::IDLE: begin
          if (in_valid) begin
            op_q  <= op_in;
            dvd   <= abs_a;
            dvs   <= abs_b;
            neg_q <= operand_a[XLEN-1] ^ operand_b[XLEN-1];
            neg_r <= operand_a[XLEN-1];
            rem   <= '0;
            count <= '0;
            if (div_zero) begin
              h     <= alu_defs::is_rem_op(op_in) ? operand_a : '1;
              state <= alu_defs::DONE;
            end else if (overflow) begin
              h     <= alu_defs::is_rem_op(op_in) ? '0 : MIN_NEG;
              state <= alu_defs::DONE;
            end else begin
              state <= alu_defs::CALC;
            end
          end
        end
        alu_defs::CALC: begin
          rem   <= rem_nxt;
          dvd   <= q_raw;
          count <= count + 1'b1;
          if (count == LAST_CNT) begin
            h     <= alu_defs::is_rem_op(op_q) ? r_fix : q_fix;
            state <= alu_defs::DONE;
          end
        end
        alu_defs::DONE: begin
          if (out_ready) state <= alu_defs::IDLE;
        end
        default: state <= alu_defs::IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [1:0]  div_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] h;

  int checks = 0;
  int errors = 0;

  divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .div_op    (div_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .h         (h)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_h;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op at the next negedge and wait (bounded) for out_valid.
  // lat counts edges after the accept edge until out_valid is seen.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1; div_op = op; operand_a = a; operand_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = h;
  endtask

  task automatic retire(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " in_ready after retire"}, 32'(in_ready), 32'd1);
    check({name, " out_valid after retire"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    int          lat;

    vecs.push_back('{"divu 100/7",        2'b01, 32'd100,      32'd7,        32'h0000000E, 33});
    vecs.push_back('{"remu 100/7",        2'b11, 32'd100,      32'd7,        32'h00000002, 33});
    vecs.push_back('{"div -7/2",          2'b00, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
    vecs.push_back('{"rem -7/2",          2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
    vecs.push_back('{"div 7/-2",          2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
    vecs.push_back('{"rem 7/-2",          2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
    vecs.push_back('{"div by 0",          2'b00, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{"rem by 0",          2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 1});
    vecs.push_back('{"divu by 0",         2'b01, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{"remu by 0",         2'b11, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 1});
    vecs.push_back('{"div overflow",      2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{"rem overflow",      2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vecs.push_back('{"divu min/-1",       2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
    vecs.push_back('{"div min/2",         2'b00, 32'h80000000, 32'h00000002, 32'hC0000000, 33});
    vecs.push_back('{"divu min/2",        2'b01, 32'h80000000, 32'h00000002, 32'h40000000, 33});
    vecs.push_back('{"remu ffffffff/16",  2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 33});

    // Reset with an operation offered: reset must win.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    div_op = 2'b01; operand_a = 32'd9; operand_b = 32'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset h", h, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset out_valid", 32'(out_valid), 32'd0);

    foreach (vecs[i]) begin
      check({vecs[i].name, " in_ready before issue"}, 32'(in_ready), 32'd1);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].name, " h"}, res, vecs[i].exp_h);
      check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
      retire(vecs[i].name);
    end

    // Backpressure: result held for 5 cycles while in_valid pulses are ignored.
    do_op(2'b01, 32'd100, 32'd7, res, lat);
    check("bp h", res, 32'h0000000E);
    check("bp latency", 32'(lat), 32'd33);
    held = h;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      div_op = 2'b01; operand_a = 32'd50; operand_b = 32'd5;
      @(negedge clk);
      check("bp h stable", h, held);
      check("bp in_ready low", 32'(in_ready), 32'd0);
      check("bp out_valid high", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    retire("bp");
    repeat (2) @(negedge clk);
    check("bp no ghost op", 32'(out_valid), 32'd0);
    check("bp still idle", 32'(in_ready), 32'd1);

    // Reset after 10 CALC cycles discards the op.
    @(negedge clk);
    in_valid = 1'b1; div_op = 2'b01; operand_a = 32'hFFFFFFFF; operand_b = 32'h10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid calc in_ready", 32'(in_ready), 32'd0);
    check("mid calc out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort h", h, 32'd0);
    do_op(2'b01, 32'hFFFFFFFF, 32'h10, res, lat);
    check("post abort h", res, 32'h0FFFFFFF);
    check("post abort latency", 32'(lat), 32'd33);
    retire("post abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
